// File: rtl/lc4_div_seq.sv
// LC4 sequential unsigned divider, restoring shift-subtract, BITS_PER_CYCLE bits/clock.
// Optional LC4_DIV_BYZERO_FLAG_EN adds out_dbz and a 1-cycle divide-by-zero path.
module lc4_div_seq #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder
`ifdef LC4_DIV_BYZERO_FLAG_EN
  ,
  output logic             out_dbz
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH:0]   wide;

  // Quotient bits shift into the vacated low end of the dividend register.
  always_comb begin
    dvd_s = dvd_q;
    rem_s = rem_q;
    wide  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      wide  = {rem_s, dvd_s[WIDTH-1]};
      dvd_s = dvd_s << 1;
      if (wide >= {1'b0, dvs_q}) begin
        wide     = wide - {1'b0, dvs_q};
        dvd_s[0] = 1'b1;
      end
      rem_s = wide[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = in_dividend;
          dvs_d   = in_divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (in_divisor == '0);
          state_d = BUSY;
`ifdef LC4_DIV_BYZERO_FLAG_EN
          if (in_divisor == '0) begin
            quo_d   = '0;
            rmd_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        dvd_d = dvd_s;
        rem_d = rem_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = dbz_q ? '0 : dvd_s;
          rmd_d   = dbz_q ? '0 : rem_s;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign out_quotient  = quo_q;
  assign out_remainder = rmd_q;
`ifdef LC4_DIV_BYZERO_FLAG_EN
  assign out_dbz = dbz_q;
`endif

endmodule
